// File: rtl/ftdi_pkg.sv
// Shared definitions for the FTDI transmit path: byte width and transmit FSM state encoding.
package ftdi_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } tx_state_t;

endpackage

// File: rtl/ftdi_tx_ram.sv
// Byte storage for the FTDI transmit FIFO: synchronous write, asynchronous read, contents not reset.
module ftdi_tx_ram
   import ftdi_pkg::*;
#(
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BYTE_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [BYTE_W-1:0] rd_data_c
);

   logic [BYTE_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/ftdi_tx_fifo.sv
// Transmit FIFO toward the FTDI controller: bursts out once a threshold is reached or a partial
// buffer idles too long. Define FTDI_TX_FIFO_STATS_EN to add drop_cnt/ovf rejected-push statistics.
module ftdi_tx_fifo
   import ftdi_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2   = 9,
   parameter int unsigned TX_THRESH    = 64,
   parameter int unsigned FLUSH_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                wr_en,
   input  logic [BYTE_W-1:0]   wr_data,
   output logic                full,
   output logic [DEPTH_LOG2:0] count,
   output logic                fifo_tx_rdy,
   input  logic                ftdi_rx_rdy,
   output logic [BYTE_W-1:0]   d_out
`ifdef FTDI_TX_FIFO_STATS_EN
   ,
   output logic [15:0]         drop_cnt,
   output logic                ovf
`endif
);

   localparam int unsigned DEPTH = 2**DEPTH_LOG2;
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
   localparam int unsigned TMR_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   tx_state_t              state, state_next;
   logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
   logic [TMR_W-1:0]       flush_tmr, tmr_next;
   logic [CNT_W-1:0]       count_next;
   logic                   push, pop, rdy_next, full_next;

   // Next-state, occupancy and flush-timer decode.
   always_comb begin
      push       = wr_en & ~full;
      pop        = fifo_tx_rdy & ftdi_rx_rdy;
      count_next = count + CNT_W'(push) - CNT_W'(pop);
      state_next = state;
      tmr_next   = '0;
      case (state)
         IDLE: begin
            if ((count >= CNT_W'(TX_THRESH)) || (flush_tmr == TMR_W'(FLUSH_CYCLES - 1)))
               state_next = BURST;
         end
         BURST: begin
            if (count_next == '0) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Timer only runs on a partial buffer that is sitting idle without new pushes.
      if ((state == IDLE) && (state_next == IDLE) && !push &&
          (count != '0) && (count < CNT_W'(TX_THRESH)))
         tmr_next = flush_tmr + TMR_W'(1);
      rdy_next  = (state_next == BURST) && (count_next != '0);
      full_next = (count_next == CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         flush_tmr   <= '0;
         full        <= 1'b0;
         fifo_tx_rdy <= 1'b0;
      end else begin
         state       <= state_next;
         count       <= count_next;
         flush_tmr   <= tmr_next;
         full        <= full_next;
         fifo_tx_rdy <= rdy_next;
         if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
   end

   ftdi_tx_ram #(
      .ADDR_W (DEPTH_LOG2)
   ) u_ram (
      .clk       (clk),
      .wr_en     (push),
      .wr_addr   (wr_ptr),
      .wr_data   (wr_data),
      .rd_addr   (rd_ptr),
      .rd_data_c (d_out)
   );

`ifdef FTDI_TX_FIFO_STATS_EN
   // Saturating count of rejected pushes and sticky overflow flag.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         drop_cnt <= '0;
         ovf      <= 1'b0;
      end else if (wr_en && full) begin
         if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         ovf <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/ftdi_tx_fifo.md
FTDI_TX_FIFO -- requirements
Module: ftdi_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 9, meaning FIFO depth is 2**DEPTH_LOG2 bytes.
REQ-002 SHALL have parameter TX_THRESH, default 64, meaning the occupancy that starts a burst toward the FTDI.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 1024, meaning the idle-timeout that flushes a partial burst.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en  input  1  upstream push strobe (SDRAM stream checker side).
REQ-007 SHALL have port wr_data  input  8  byte to push.
REQ-008 SHALL have port full  output  1  FIFO holds 2**DEPTH_LOG2 bytes.
REQ-009 SHALL have port count  output  DEPTH_LOG2+1  current occupancy.
REQ-010 SHALL have port fifo_tx_rdy  output  1  byte available and burst active, to the FTDI controller.
REQ-011 SHALL have port ftdi_rx_rdy  input  1  FTDI controller accepts the byte on d_out this cycle.
REQ-012 SHALL have port d_out  output  8  head-of-FIFO byte, driven to the FTDI data bus.

Function
REQ-013 SHALL accept a push at an edge when wr_en=1 and full=0; the byte is written at wr_ptr and wr_ptr increments modulo depth.
REQ-014 SHALL pop at an edge when fifo_tx_rdy=1 and ftdi_rx_rdy=1; rd_ptr increments modulo depth.
REQ-015 SHALL drive d_out as the byte at rd_ptr, read asynchronously from storage; d_out is don't-care when count=0.
REQ-016 SHALL update count after each edge: +1 push only, -1 pop only, unchanged on simultaneous push and pop.
REQ-017 SHALL reject a push while full=1, even with a simultaneous pop; the rejected byte is discarded.
REQ-018 SHALL never pop when count=0 (fifo_tx_rdy is forced low).
REQ-019 SHALL wrap both pointers at depth with no lost or repeated bytes; full = (count = depth).
REQ-020 SHALL implement states IDLE and BURST; IDLE -> BURST when count >= TX_THRESH or flush_tmr reaches FLUSH_CYCLES-1.
REQ-021 SHALL make BURST -> IDLE on the edge at which count becomes 0.
REQ-022 SHALL drive fifo_tx_rdy = (state = BURST) and (count != 0), decoded from registers only.
REQ-023 SHALL run flush_tmr in IDLE while 0 < count < TX_THRESH, incrementing per cycle, clearing on any push or on leaving IDLE, and holding 0 when count=0.
REQ-024 SHALL hold flush_tmr at 0 in BURST.
REQ-025 SHALL have a one-cycle latency from a push into an empty FIFO to that byte on d_out and count=1.

Reset
REQ-026 SHALL on n_rst=0 asynchronously set wr_ptr=0, rd_ptr=0, count=0, full=0, flush_tmr=0, state=IDLE, fifo_tx_rdy=0.
REQ-027 SHALL not reset storage contents.
REQ-028 SHALL, on reset mid-burst, drop all buffered bytes and drive fifo_tx_rdy=0 immediately, without waiting for a clock.

Configuration
REQ-029 SHALL compile with FTDI_TX_FIFO_STATS_EN defined: adds output drop_cnt (16 bits, saturating count of rejected pushes, reset 0) and output ovf (sticky, set on the first rejected push, cleared only by reset).
REQ-030 SHALL compile without FTDI_TX_FIFO_STATS_EN: no drop_cnt/ovf ports and no related logic.

Structure
REQ-031 SHALL take the byte width constant (8) and the IDLE/BURST state encoding from shared package ftdi_pkg.
REQ-032 SHALL place storage in sub-module ftdi_tx_ram: synchronous write, asynchronous read, 2**DEPTH_LOG2 x 8.

Verification
REQ-033 SHALL cover push 0x00..0x3F (64 bytes) with ftdi_rx_rdy=1 -> fifo_tx_rdy rises the cycle after the 64th push; bytes emerge in order; BURST -> IDLE at count=0.
REQ-034 SHALL cover push 5 bytes and then idle -> fifo_tx_rdy stays 0 for FLUSH_CYCLES cycles, then rises; exactly 5 bytes pop.
REQ-035 SHALL cover filling to 512 with ftdi_rx_rdy=0 and pushing 0xAA with a simultaneous pop -> 0xAA dropped, count=511 (with STATS_EN: drop_cnt=1, ovf=1).
REQ-036 SHALL cover 2000 bytes of an incrementing pattern with random ftdi_rx_rdy -> pointers wrap, output sequence matches input exactly.
REQ-037 SHALL cover asserting n_rst mid-burst at count=100 -> fifo_tx_rdy=0 and count=0 before the next edge; state=IDLE after reset release.
